// File: rtl/tbird_pkg.sv
// Shared encodings for the T-bird taillight FSM and its receive-side decoder,
// plus the legal-step and completion-mode helpers used by the decoder.
package tbird_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    L1   = 3'b001,
    L2   = 3'b011,
    L3   = 3'b010,
    R1   = 3'b101,
    R2   = 3'b111,
    R3   = 3'b110,
    LR3  = 3'b100
  } t_tbird_lights_state;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    HAZ   = 2'b11
  } t_tbird_mode;

  // Decoder tracker: last legal lamp state, or resynchronising after a violation.
  typedef struct packed {
    logic                sync;
    t_tbird_lights_state st;
  } t_tbird_tracker;

  localparam t_tbird_tracker TRK_IDLE = '{sync: 1'b0, st: IDLE};

  // Non-IDLE states never repeat: the source FSM advances every cycle.
  function automatic logic tbird_legal_step(input t_tbird_lights_state prev,
                                            input t_tbird_lights_state cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      IDLE:          ok = (cur == IDLE) || (cur == L1) || (cur == R1) || (cur == LR3);
      L1:            ok = (cur == L2) || (cur == LR3);
      L2:            ok = (cur == L3) || (cur == LR3);
      R1:            ok = (cur == R2) || (cur == LR3);
      R2:            ok = (cur == R3) || (cur == LR3);
      L3, R3, LR3:   ok = (cur == IDLE);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Mode reported when a sequence ends by stepping from prev into IDLE.
  function automatic t_tbird_mode tbird_done_mode(input t_tbird_lights_state prev);
    t_tbird_mode m;
    m = NONE;
    case (prev)
      L3:      m = LEFT;
      R3:      m = RIGHT;
      LR3:     m = HAZ;
      default: m = NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tbird_pattern_classify.sv
// Combinational classifier: maps the observed {left,right} lamp patterns onto
// the shared lamp-state encoding, flagging anything the FSM can never drive.
module tbird_pattern_classify
  import tbird_pkg::*;
(
  input  logic [2:0]          l_lights,
  input  logic [2:0]          r_lights,
  output t_tbird_lights_state state,
  output logic                bad
);

  always_comb begin
    state = IDLE;
    bad   = 1'b0;
    case ({l_lights, r_lights})
      6'b000_000: state = IDLE;
      6'b001_000: state = L1;
      6'b011_000: state = L2;
      6'b111_000: state = L3;
      6'b000_001: state = R1;
      6'b000_011: state = R2;
      6'b000_111: state = R3;
      6'b111_111: state = LR3;
      default:    bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/tbird_light_decoder.sv
// Receive-side monitor for the T-bird taillights: tracks the lamp sequence,
// reports completed sequences by mode, and flags protocol violations.
module tbird_light_decoder
  import tbird_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [2:0]       l_lights,
  input  logic [2:0]       r_lights,
  input  logic             clr,
  output logic             done,
  output t_tbird_mode      mode,
  output logic             err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt_left,
  output logic [CNT_W-1:0] cnt_right,
  output logic [CNT_W-1:0] cnt_haz
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  t_tbird_lights_state pat_state;
  logic                pat_bad;
  t_tbird_tracker      trk_q;
  t_tbird_tracker      trk_d;
  logic                done_d;
  logic                err_d;
  t_tbird_mode         mode_d;
  logic                inc_left;
  logic                inc_right;
  logic                inc_haz;

  tbird_pattern_classify u_classify (
    .l_lights (l_lights),
    .r_lights (r_lights),
    .state    (pat_state),
    .bad      (pat_bad)
  );

  always_comb begin
    trk_d     = trk_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mode_d    = mode;
    inc_left  = 1'b0;
    inc_right = 1'b0;
    inc_haz   = 1'b0;
    if (trk_q.sync) begin
      // Resynchronise silently on the first clean IDLE pattern.
      if (!pat_bad && (pat_state == IDLE)) begin
        trk_d = TRK_IDLE;
      end
    end else if (pat_bad || !tbird_legal_step(trk_q.st, pat_state)) begin
      err_d      = 1'b1;
      trk_d.sync = 1'b1;
      trk_d.st   = IDLE;
    end else begin
      trk_d.st = pat_state;
      // A legal step into IDLE from a non-IDLE state can only come from L3/R3/LR3.
      if ((pat_state == IDLE) && (trk_q.st != IDLE)) begin
        done_d    = 1'b1;
        mode_d    = tbird_done_mode(trk_q.st);
        inc_left  = (mode_d == LEFT);
        inc_right = (mode_d == RIGHT);
        inc_haz   = (mode_d == HAZ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      trk_q      <= TRK_IDLE;
      done       <= 1'b0;
      err        <= 1'b0;
      mode       <= NONE;
      err_sticky <= 1'b0;
      cnt_left   <= '0;
      cnt_right  <= '0;
      cnt_haz    <= '0;
    end else begin
      trk_q <= trk_d;
      done  <= done_d;
      err   <= err_d;
      mode  <= mode_d;
      // A new violation outranks a coincident clear.
      if (err_d) begin
        err_sticky <= 1'b1;
      end else if (clr) begin
        err_sticky <= 1'b0;
      end
      if (clr) begin
        cnt_left <= '0;
      end else if (inc_left && (cnt_left != '1)) begin
        cnt_left <= cnt_left + CNT_ONE;
      end
      if (clr) begin
        cnt_right <= '0;
      end else if (inc_right && (cnt_right != '1)) begin
        cnt_right <= cnt_right + CNT_ONE;
      end
      if (clr) begin
        cnt_haz <= '0;
      end else if (inc_haz && (cnt_haz != '1)) begin
        cnt_haz <= cnt_haz + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/tbird_light_decoder.md
Name: tbird_light_decoder

Overview:
- Receive-side monitor for the T-bird taillight interface: samples l_lights/r_lights every clock and reconstructs the commanded mode (left, right or hazard).
- Checks each light sequence against the legal tail-light protocol, counts completed sequences, and flags protocol violations.
- Sits on the same clock as the taillight FSM, next to it or in the bench, as a checker and status source.

Parameters:
CNT_W, 8, width of each saturating completed-sequence counter

Ports:
clk  input  1  system clock
rst_b  input  1  asynchronous active-low reset
l_lights  input  3  observed left lamp pattern
r_lights  input  3  observed right lamp pattern
clr  input  1  synchronous clear of counters and err_sticky
done  output  1  one-cycle pulse: a sequence completed legally
mode  output  2  mode of the last completed sequence (t_tbird_mode)
err  output  1  one-cycle pulse: protocol violation detected
err_sticky  output  1  set by err, held until clr
cnt_left  output  CNT_W  completed left sequences, saturating
cnt_right  output  CNT_W  completed right sequences, saturating
cnt_haz  output  CNT_W  completed hazard sequences, saturating

Behaviour:
- Reset: one clock, clk; rst_b is asynchronous, active low. While rst_b=0: tracker=IDLE, done=0, err=0, mode=NONE, err_sticky=0, all counters=0. Reset mid-sequence discards the partial sequence with no done and no err.
- Pattern classification (combinational), {l,r}:
  - 000/000=IDLE
  - 001/000=L1, 011/000=L2, 111/000=L3
  - 000/001=R1, 000/011=R2, 000/111=R3
  - 111/111=LR3
  - Every other combination is BAD.
- Tracker: a registered copy of the last legal classified state, plus a SYNC state.
- Legal transitions (prev -> current):
  - IDLE -> IDLE, L1, R1, LR3
  - L1 -> L2, LR3; L2 -> L3, LR3; L3 -> IDLE
  - R1 -> R2, LR3; R2 -> R3, LR3; R3 -> IDLE
  - LR3 -> IDLE
  - Repeats of a non-IDLE state are illegal, because the source advances every cycle.
- Completion: a legal transition into IDLE from L3, R3 or LR3.
  - Takes effect at the same posedge that samples the IDLE pattern: done=1 for exactly one cycle.
  - mode becomes LEFT, RIGHT or HAZ respectively.
  - The matching counter increments, saturating at all-ones.
  - An L1/L2/R1/R2 -> LR3 abort completes as HAZ.
- Violation: a BAD pattern, or an illegal transition, sampled while the tracker is not in SYNC.
  - err=1 for one cycle and err_sticky=1.
  - Tracker enters SYNC. No counter or mode change.
- SYNC: ignores all patterns (no further err) until the IDLE pattern is sampled, then returns to IDLE with no done.
- Latency: the pattern present before posedge N is reflected in done/err/counters after posedge N (1 cycle, registered outputs).
- mode holds its value between completions; it is unaffected by clr.
- clr=1 at a posedge zeroes the counters and err_sticky.
  - If clr coincides with a completion, the counter ends at 0.
  - If clr coincides with an error, err_sticky ends at 1 (set wins).
- done and err are never asserted in the same cycle.

Decomposition:
- Package tbird_pkg holds:
  - t_tbird_lights_state, moved there so the FSM and decoder share one encoding: IDLE=000, L1=001, L2=011, L3=010, R1=101, R2=111, R3=110, LR3=100.
  - t_tbird_mode: NONE=00, LEFT=01, RIGHT=10, HAZ=11.
  - A legal-transition function.
- One sub-module, tbird_pattern_classify: combinational; lights in; state plus bad flag out.

Test Plan:
- Reset, then apply 001/000, 011/000, 111/000, 000/000 on consecutive cycles -> done pulses once after the fourth edge; mode=LEFT; cnt_left=1; err never set.
- Apply 000/001, 000/011, then 111/111, then 000/000 -> done once with mode=HAZ; cnt_haz=1; cnt_right=0.
- Apply 001/000, then 001/000 again (stall) -> err pulses one cycle; err_sticky=1. Then 111/000, 000/000 -> no further err and no done; the next legal right sequence gives done with mode=RIGHT.
- Apply BAD pattern 010/000 from IDLE -> err=1 after 1 cycle; counters unchanged. Assert clr -> err_sticky=0.
- CNT_W=2, run four right sequences -> cnt_right reads 1, 2, 3, 3 (saturates). Assert clr on the fourth done cycle -> cnt_right=0.
- Drop rst_b mid-sequence after 011/000 -> all outputs 0 and mode=NONE immediately. After release, 000/000 yields neither done nor err.
